hazard_sequencer: RTL
=====================

# hazard_sequencer

Pipeline hazard controller for the 5-stage MIPS32 core. It watches the instruction in decode and the ID/EX and EX/MEM destination fields, and drives `Data_Hazard` and `Control_Hazard` into the decode stage. It also drives the PC and IF/ID write enables and the qualified branch/jump PC-select strobes. A small state machine sequences multi-cycle stalls and the one-cycle wrong-path flush after a taken branch or jump. Saturating performance counters record stall and flush activity.

## Interface
Parameters:
- `CNT_W`, default 16: width of the performance counters.
- `BEQ_OPCODE`, default 6'h04: opcode of the branch resolved in decode.
- `LW_OPCODE`, default 6'h23: load opcode; `rt` is treated as a destination, not a source.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `id_instr` in 32: instruction currently in ID.
- `branch_taken` in 1: raw branch-equal result from ID.
- `jump` in 1: raw jump decode from ID.
- `id_ex_reg_write` in 1, `id_ex_mem_read` in 1, `id_ex_dest` in 5: producer in EX.
- `ex_mem_reg_write` in 1, `ex_mem_dest` in 5: producer in MEM.
- `Data_Hazard` out 1: high = no data hazard; low = bubble ID controls.
- `Control_Hazard` out 1: high = squash the ID instruction.
- `pc_write` out 1, `if_id_write` out 1: advance enables.
- `pc_sel_branch` out 1, `pc_sel_jump` out 1: qualified redirect strobes.
- `stall_cycles` out CNT_W, `flush_count` out CNT_W.

## Operation
Sources:
- `rs` = id_instr[25:21].
- `rt` = id_instr[20:16]; it is a source unless the opcode is `LW_OPCODE`.
- Register 0 never matches.

Stall need, computed in RUN only; the maximum of the applicable terms is taken:
- 2 if the ID instruction is a branch and `id_ex_reg_write` is set and `id_ex_dest` matches a source.
- 1 if the ID instruction is a branch and `ex_mem_reg_write` is set and `ex_mem_dest` matches a source.
- 1 if `id_ex_mem_read` is set and `id_ex_dest` matches a source (load-use).
- Branch compares read the register file directly, and the register file writes through, so a producer in WB is never a hazard.

States:
- **RUN**
  - need=0: `Data_Hazard`=1, enables=1.
  - need=0 and (`branch_taken` or `jump`): assert `pc_sel_branch` / `pc_sel_jump`; next state is FLUSH.
  - need≥1: `Data_Hazard`=0, enables=0, `pc_sel_*`=0.
  - need=2: load `cnt`=1, go to STALL.
  - need=1: stay in RUN and re-evaluate next cycle.
- **STALL**: `Data_Hazard`=0, enables=0, `pc_sel_*`=0. Decrement `cnt`; when `cnt` reaches 0, go to RUN.
- **FLUSH**: `Control_Hazard`=1, `Data_Hazard`=1, enables=1, `pc_sel_*`=0. The wrong-path branch/jump is ignored. Next state is always RUN.

Rules:
- A branch or jump under stall is not acted on until need=0.
- Counters:
  - `stall_cycles` +1 on every cycle with `Data_Hazard`=0.
  - `flush_count` +1 on every entry to FLUSH.
  - Both saturate at all-ones.

## Timing
- Reset values:
  - state=RUN, `cnt`=0, counters=0.
  - `Data_Hazard`=1, `Control_Hazard`=0.
  - `pc_write`=1, `if_id_write`=1, `pc_sel_*`=0.
- `Data_Hazard`, enables and `pc_sel_*` are combinational from state and inputs, with zero-cycle latency within the cycle of detection.
- `Control_Hazard` is a function of state only, so it is effectively registered: high exactly one cycle after the redirect.
- Stall lengths:
  - Load-use: 1 cycle.
  - Branch on an EX producer: 2 cycles.
  - Branch on a MEM producer: 1 cycle.
- Reset asserted mid-STALL or mid-FLUSH forces RUN asynchronously; the pending count is discarded.
- Simultaneous stall need and `branch_taken`: the stall wins and the redirect is deferred.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants (`BEQ_OPCODE`, `LW_OPCODE`, J opcode).
  - State enum {RUN, STALL, FLUSH}.
  - Field-slice constants for `rs`, `rt`, `rd`.
- One natural sub-module: `sat_counter` (CNT_W-bit, increment enable, saturating), instantiated twice.
- The hazard-need logic stays inline as a combinational block.

## Test plan
- Load `lw $2` in EX (`id_ex_mem_read`=1, `id_ex_dest`=2), ID=`add $3,$2,$4` → `Data_Hazard`=0 for exactly 1 cycle; `pc_write`=0 for that cycle; `stall_cycles`=1.
- `add $5` in EX (`id_ex_reg_write`=1, `id_ex_dest`=5), ID=`beq $5,$0` → 2 stall cycles (RUN→STALL→RUN); then `branch_taken`=1 → `pc_sel_branch`=1, then `Control_Hazard`=1 for one cycle; `flush_count`=1.
- `id_ex_dest`=0 with `id_ex_reg_write`=1, ID=`beq $0,$0` → no stall; only `Control_Hazard` after taken.
- In FLUSH with `jump`=1 still present → `pc_sel_jump`=0; returns to RUN with no second flush.
- Assert `reset` while in STALL with `cnt`=1 → immediately RUN, `Data_Hazard`=1, counters=0.
- Force 2^CNT_W+3 stall cycles → `stall_cycles` holds at all-ones.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline constants, state encoding and helpers.
// Used by the hazard sequencer and its performance counters.
package mips_pkg;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_J   = 6'h02;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic src_match(
        input logic [4:0] dest,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       rt_src
    );
        return (dest != 5'd0) &&
               ((dest == rs) || (rt_src && (dest == rt)));
    endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter for stall/flush performance statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, sticking at the maximum value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Decode-stage hazard controller: load-use and branch-operand stalls,
// wrong-path flush after a taken branch or jump, and activity counters.
module hazard_sequencer
    import mips_pkg::*;
#(
    parameter int         CNT_W      = 16,
    parameter logic [5:0] BEQ_OPCODE = OP_BEQ,
    parameter logic [5:0] LW_OPCODE  = OP_LW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_dest,
    input  logic             ex_mem_reg_write,
    input  logic [4:0]       ex_mem_dest,
    output logic             Data_Hazard,
    output logic             Control_Hazard,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pc_sel_branch,
    output logic             pc_sel_jump,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_t  state;
    logic [1:0] cnt;
    logic [1:0] need;
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       is_branch;
    logic       rt_src;
    logic       ex_hit;
    logic       mem_hit;
    logic       go_flush;
    logic       unused_bits;

    assign opcode      = id_instr[OP_MSB:OP_LSB];
    assign rs          = id_instr[RS_MSB:RS_LSB];
    assign rt          = id_instr[RT_MSB:RT_LSB];
    assign is_branch   = (opcode == BEQ_OPCODE);
    assign rt_src      = (opcode != LW_OPCODE);
    assign ex_hit      = src_match(id_ex_dest, rs, rt, rt_src);
    assign mem_hit     = src_match(ex_mem_dest, rs, rt, rt_src);
    assign unused_bits = ^id_instr[RD_MSB:0];

    // Stall need: worst of the branch-operand and load-use terms, RUN only.
    // WB producers are covered by the write-through register file.
    always_comb begin
        need = 2'd0;
        if (state == RUN) begin
            if (is_branch && id_ex_reg_write && ex_hit) begin
                need = 2'd2;
            end else if ((is_branch && ex_mem_reg_write && mem_hit) ||
                         (id_ex_mem_read && ex_hit)) begin
                need = 2'd1;
            end
        end
    end

    // A redirect is only honoured once no stall is pending.
    assign go_flush = (state == RUN) && (need == 2'd0) &&
                      (branch_taken || jump);

    // Same-cycle stall and redirect controls from state and inputs.
    always_comb begin
        Data_Hazard   = 1'b1;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        pc_sel_branch = 1'b0;
        pc_sel_jump   = 1'b0;
        unique case (state)
            RUN: begin
                if (need != 2'd0) begin
                    Data_Hazard = 1'b0;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end else begin
                    pc_sel_branch = branch_taken;
                    pc_sel_jump   = jump;
                end
            end
            STALL: begin
                Data_Hazard = 1'b0;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
            default: ;
        endcase
    end

    // Sequencer: multi-cycle stalls and the one-cycle wrong-path squash.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            cnt            <= 2'd0;
            Control_Hazard <= 1'b0;
        end else begin
            Control_Hazard <= go_flush;
            unique case (state)
                RUN: begin
                    if (need == 2'd2) begin
                        state <= STALL;
                        cnt   <= 2'd1;
                    end else if (go_flush) begin
                        state <= FLUSH;
                    end
                end
                STALL: begin
                    if (cnt <= 2'd1) begin
                        cnt   <= 2'd0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                FLUSH: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (~Data_Hazard),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (go_flush),
        .count (flush_count)
    );

endmodule
